// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: funct3 codes,
// FSM state encoding, load extension and store byte-lane steering.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Pick the addressed byte/halfword out of a little-endian word and extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  funct3);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {lane, 3'b000});
        h = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    return {{24{b[7]}}, b};
            F3_BU:   return {24'h000000, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'h0000, h};
            F3_W:    return word;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Byte enables for a store; zero for anything that is not SB/SH/SW.
    function automatic logic [3:0] store_be(input logic [1:0] lane,
                                            input logic [2:0] funct3);
        case (funct3)
            F3_B:    return 4'b0001 << lane;
            F3_H:    return lane[1] ? 4'b1100 : 4'b0011;
            F3_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate right-aligned store data across all lanes so the byte
    // enables alone decide which lanes change.
    function automatic logic [31:0] store_data(input logic [31:0] wdata,
                                               input logic [2:0]  funct3);
        case (funct3)
            F3_B:    return {4{wdata[7:0]}};
            F3_H:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    // Error check for an access: misalignment, and also any funct3 that is
    // not a legal load (loads) or a legal store (stores).
    function automatic logic misaligned(input logic [1:0] lane,
                                        input logic [2:0] funct3,
                                        input logic       we);
        logic legal;
        if (we) begin
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                    (funct3 == F3_BU) || (funct3 == F3_HU);
        end
        if (!legal) begin
            return 1'b1;
        end
        if ((funct3 == F3_H || funct3 == F3_HU) && lane[0]) begin
            return 1'b1;
        end
        if (funct3 == F3_W && lane != 2'b00) begin
            return 1'b1;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables and a read register that
// is only updated when a read is requested (on the ACCESS edge).
module dmem_array
    import dmem_pkg::*;
#(
    parameter int    ADDR_WIDTH = 17,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic                  rd_i,
    input  logic [ADDR_WIDTH-3:0] idx_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Byte-lane writes and registered read; contents are never reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i && be_i[i]) begin
                mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        if (rd_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store port.
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both 1; req_ready_o is high only in IDLE (and not in reset),
// the initiator must hold req_* stable until that edge, and rsp_valid_o is a
// single-cycle strobe with no back-pressure.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int    DATA_WIDTH = 32,
    parameter int    ADDR_WIDTH = 17,
    parameter int    LATENCY    = 2,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [31:0]           req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [2:0]            req_funct3_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output state_t                state_o
);

    // Counter reload for the WAIT state; LATENCY is limited to 0..15.
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  accept;
    logic                  access;

    // Request latch
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [2:0]            f3_q;

    // Response shaping state captured on the ACCESS edge
    logic                  rsp_load_q;
    logic                  rsp_err_q;
    logic [1:0]            rsp_lane_q;
    logic [2:0]            rsp_f3_q;

    // Operands of the access actually being executed
    logic                  acc_from_req;
    logic                  acc_we;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [31:0]           acc_wdata;
    logic [2:0]            acc_f3;
    logic                  acc_err;
    logic                  mem_we;
    logic                  mem_rd;
    logic [31:0]           mem_rdata;

    // Upper address bits wrap and are deliberately not decoded.
    logic                  unused_addr_hi;
    assign unused_addr_hi = ^req_addr_i[31:ADDR_WIDTH];

    assign req_ready_o = (state_q == IDLE) && rst;
    assign state_o     = state_q;

    // Next-state logic, wait counter and access strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        access  = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = LAT_M1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // With zero latency the access happens on the accept edge itself, so the
    // operands come straight from the request port instead of the latch.
    always_comb begin
        acc_from_req = (state_q == IDLE);
        acc_we       = acc_from_req ? req_we_i                     : we_q;
        acc_addr     = acc_from_req ? req_addr_i[ADDR_WIDTH-1:0]   : addr_q;
        acc_wdata    = acc_from_req ? req_wdata_i                  : wdata_q;
        acc_f3       = acc_from_req ? req_funct3_i                 : f3_q;
        acc_err      = misaligned(acc_addr[1:0], acc_f3, acc_we);
        // Reset asserted on the ACCESS edge suppresses the write.
        mem_we       = access && acc_we && !acc_err && rst;
        mem_rd       = access && !acc_we && !acc_err && rst;
    end

    // FSM state, counter and response registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            rsp_load_q <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_lane_q <= 2'b00;
            rsp_f3_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (access) begin
                rsp_load_q <= !acc_we && !acc_err;
                rsp_err_q  <= acc_err;
                rsp_lane_q <= acc_addr[1:0];
                rsp_f3_q   <= acc_f3;
            end
        end
    end

    // Capture the request fields on the accept edge only.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we_i;
            addr_q  <= req_addr_i[ADDR_WIDTH-1:0];
            wdata_q <= req_wdata_i;
            f3_q    <= req_funct3_i;
        end
    end

    dmem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .be_i    (store_be(acc_addr[1:0], acc_f3)),
        .rd_i    (mem_rd),
        .idx_i   (acc_addr[ADDR_WIDTH-1:2]),
        .wdata_i (store_data(acc_wdata, acc_f3)),
        .rdata_o (mem_rdata)
    );

    assign rsp_valid_o = (state_q == RESP);
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_load_q ? load_extend(mem_rdata, rsp_lane_q, rsp_f3_q) : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance and a LATENCY=0
// instance share clock and reset; expected responses are queued at issue time.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int LAT = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        v2, we2, v0, we0;
    logic [31:0] a2, wd2, a0, wd0;
    logic [2:0]  f2, f0;
    logic        rdy2, rv2, err2, rdy0, rv0, err0;
    logic [31:0] rd2, rd0;
    state_t      st2, st0;

    dmem_responder #(.LATENCY(LAT)) dut2 (
        .clk(clk), .rst(rst), .req_valid_i(v2), .req_ready_o(rdy2), .req_we_i(we2),
        .req_addr_i(a2), .req_wdata_i(wd2), .req_funct3_i(f2), .rsp_valid_o(rv2),
        .rsp_rdata_o(rd2), .rsp_err_o(err2), .state_o(st2)
    );

    dmem_responder #(.LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid_i(v0), .req_ready_o(rdy0), .req_we_i(we0),
        .req_addr_i(a0), .req_wdata_i(wd0), .req_funct3_i(f0), .rsp_valid_o(rv0),
        .rsp_rdata_o(rd0), .rsp_err_o(err0), .state_o(st0)
    );

    // Which instance the tasks drive/observe
    logic        sel0 = 1'b0;
    logic        c_rdy, c_rv, c_err;
    logic [31:0] c_rdata;
    assign c_rdy   = sel0 ? rdy0 : rdy2;
    assign c_rv    = sel0 ? rv0  : rv2;
    assign c_err   = sel0 ? err0 : err2;
    assign c_rdata = sel0 ? rd0  : rd2;

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];
    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int acc_cyc = 0;
    int prev_acc = 0;

    task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_req(input logic v, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [2:0] f);
        if (sel0) begin
            v0 = v; we0 = we; a0 = a; wd0 = wd; f0 = f;
        end else begin
            v2 = v; we2 = we; a2 = a; wd2 = wd; f2 = f;
        end
    endtask

    // One complete transaction: wait for ready, issue, check latency,
    // response contents and the single-cycle strobe.
    task automatic xact(input string tag, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f, input logic [32:0] exp);
        int n;
        int lat_cur;
        logic [32:0] e;
        lat_cur = sel0 ? 0 : LAT;
        n = 0;
        while (!c_rdy && n < 50) begin
            tick();
            n++;
        end
        chk({tag, " ready"}, {32'h0, c_rdy}, 33'h1);
        set_req(1'b1, we, a, wd, f);
        exp_q.push_back(exp);
        tick();
        prev_acc = acc_cyc;
        acc_cyc  = cyc;
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        n = 1;
        while (!c_rv && n < 50) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, 33'(n), 33'(lat_cur + 1));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_FFFF_FFFF;
        chk({tag, " data"}, {c_err, c_rdata}, e);
        tick();
        chk({tag, " one-shot"}, {31'h0, c_rv, c_rdy}, 33'h1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int acc_n;
        int rsp_n;
        logic rdy_prev;
        logic [32:0] e;

        sel0 = 1'b0;
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        sel0 = 1'b1;
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        sel0 = 1'b0;

        // Reset state
        rst = 1'b0;
        tick(); tick(); tick();
        chk("reset ready L2", {32'h0, rdy2}, 33'h0);
        chk("reset ready L0", {32'h0, rdy0}, 33'h0);
        chk("reset rsp L2", {rv2, err2, rd2[30:0]}, 33'h0);
        chk("reset rdata L2", {1'b0, rd2}, 33'h0);
        chk("reset state L2", {31'h0, st2}, {31'h0, IDLE});
        rst = 1'b1;
        tick();
        chk("ready after release", {31'h0, rdy2, rdy0}, 33'h3);

        // Store word then load it back; accept spacing is LAT+2
        xact("sw 100", 1'b1, 32'h100, 32'hDEADBEEF, F3_W, {1'b0, 32'h0});
        xact("lw 100", 1'b0, 32'h100, 32'h0, F3_W, {1'b0, 32'hDEADBEEF});
        chk("throughput L2", 33'(acc_cyc - prev_acc), 33'(LAT + 2));

        // Byte store with sign/zero extended loads
        xact("sb 103", 1'b1, 32'h103, 32'h00000080, F3_B, {1'b0, 32'h0});
        xact("lb 103", 1'b0, 32'h103, 32'h0, F3_B, {1'b0, 32'hFFFFFF80});
        xact("lbu 103", 1'b0, 32'h103, 32'h0, F3_BU, {1'b0, 32'h00000080});
        xact("lw 100 b", 1'b0, 32'h100, 32'h0, F3_W, {1'b0, 32'h80ADBEEF});

        // Halfword store, halfword loads, error cases
        xact("sh 102", 1'b1, 32'h102, 32'h00001234, F3_H, {1'b0, 32'h0});
        xact("lhu 102", 1'b0, 32'h102, 32'h0, F3_HU, {1'b0, 32'h00001234});
        xact("lh 100", 1'b0, 32'h100, 32'h0, F3_H, {1'b0, 32'hFFFFBEEF});
        xact("lb 100", 1'b0, 32'h100, 32'h0, F3_B, {1'b0, 32'hFFFFFFEF});
        xact("lbu 101", 1'b0, 32'h101, 32'h0, F3_BU, {1'b0, 32'h000000BE});
        xact("lh 101 err", 1'b0, 32'h101, 32'h0, F3_H, {1'b1, 32'h0});
        xact("sw 102 err", 1'b1, 32'h102, 32'hFFFFFFFF, F3_W, {1'b1, 32'h0});
        xact("lw f3=011 err", 1'b0, 32'h100, 32'h0, 3'b011, {1'b1, 32'h0});
        xact("store f3=100 err", 1'b1, 32'h100, 32'h0, 3'b100, {1'b1, 32'h0});
        xact("lw 100 c", 1'b0, 32'h100, 32'h0, F3_W, {1'b0, 32'h1234BEEF});
        xact("lw wrap", 1'b0, 32'h00020100, 32'h0, F3_W, {1'b0, 32'h1234BEEF});

        // Valid held high across WAIT/RESP: one accept per LAT+2 cycles
        set_req(1'b1, 1'b0, 32'h100, 32'h0, F3_W);
        acc_n = 0;
        rsp_n = 0;
        for (int k = 0; k < 3 * (LAT + 2); k++) begin
            rdy_prev = c_rdy;
            tick();
            if (rdy_prev) begin
                acc_n++;
                exp_q.push_back({1'b0, 32'h1234BEEF});
            end
            if (c_rv) begin
                rsp_n++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_FFFF_FFFF;
                chk("held valid data", {c_err, c_rdata}, e);
            end
        end
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        chk("held valid accepts", 33'(acc_n), 33'd3);
        chk("held valid responses", 33'(rsp_n), 33'd3);
        exp_q.delete();

        // Reset during WAIT discards a pending store
        xact("sw 200", 1'b1, 32'h200, 32'h11223344, F3_W, {1'b0, 32'h0});
        xact("lw 200", 1'b0, 32'h200, 32'h0, F3_W, {1'b0, 32'h11223344});
        set_req(1'b1, 1'b1, 32'h200, 32'h55AA55AA, F3_W);
        tick();
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        chk("in wait", {31'h0, st2}, {31'h0, WAIT});
        rst = 1'b0;
        tick();
        chk("mid reset rv/ready", {31'h0, rv2, rdy2}, 33'h0);
        tick();
        chk("mid reset state", {31'h0, st2}, {31'h0, IDLE});
        rst = 1'b1;
        tick();
        chk("post reset ready/rv", {31'h0, rdy2, rv2}, 33'h2);
        chk("post reset rsp", {err2, rd2}, 33'h0);
        xact("lw 200 after rst", 1'b0, 32'h200, 32'h0, F3_W, {1'b0, 32'h11223344});

        // Reset asserted exactly on the ACCESS edge: no write
        set_req(1'b1, 1'b1, 32'h200, 32'hCAFEF00D, F3_W);
        tick();
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        for (int k = 0; k < LAT - 1; k++) begin
            tick();
        end
        rst = 1'b0;
        tick();
        chk("access-edge reset rv", {32'h0, rv2}, 33'h0);
        rst = 1'b1;
        tick();
        xact("lw 200 access rst", 1'b0, 32'h200, 32'h0, F3_W, {1'b0, 32'h11223344});

        // Zero-latency instance: next-cycle response, 2-cycle throughput
        sel0 = 1'b1;
        xact("L0 sw 40", 1'b1, 32'h40, 32'hA5A5A5A5, F3_W, {1'b0, 32'h0});
        xact("L0 lw 40", 1'b0, 32'h40, 32'h0, F3_W, {1'b0, 32'hA5A5A5A5});
        chk("L0 throughput a", 33'(acc_cyc - prev_acc), 33'd2);
        xact("L0 lb 41", 1'b0, 32'h41, 32'h0, F3_B, {1'b0, 32'hFFFFFFA5});
        chk("L0 throughput b", 33'(acc_cyc - prev_acc), 33'd2);
        xact("L0 lh 43 err", 1'b0, 32'h43, 32'h0, F3_H, {1'b1, 32'h0});
        sel0 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
